// File: rtl/cdc_pkg.sv
// Shared constants and helpers for the multi-channel CDC input conditioner.
// Edge-count mode selectors and the glitch-filter counter width live here.
package cdc_pkg;

    localparam int CNT_RISE = 0;
    localparam int CNT_FALL = 1;
    localparam int CNT_BOTH = 2;

    // Wide enough to hold 0..FILTER_CYCLES; FILTER_CYCLES=1 still yields one bit.
    function automatic int filter_cnt_width(input int filter_cycles);
        return $clog2(filter_cycles + 1);
    endfunction

endpackage

// File: rtl/cdc_input_conditioner_if.sv
// Pin-side inputs and conditioned outputs of the CDC input conditioner.
// The master drives raw pins and controls; the slave is the conditioner itself.
interface cdc_input_conditioner_if #(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 16
);

    logic [CHANNELS-1:0]           async_in;
    logic [CHANNELS-1:0]           filter_bypass;
    logic                          count_clear;
    logic [CHANNELS-1:0]           level_out;
    logic [CHANNELS-1:0]           posedge_pulse;
    logic [CHANNELS-1:0]           negedge_pulse;
    logic [CHANNELS*CNT_WIDTH-1:0] edge_count;
    logic [CHANNELS-1:0]           count_overflow;

    modport master (
        output async_in,
        output filter_bypass,
        output count_clear,
        input  level_out,
        input  posedge_pulse,
        input  negedge_pulse,
        input  edge_count,
        input  count_overflow
    );

    modport slave (
        input  async_in,
        input  filter_bypass,
        input  count_clear,
        output level_out,
        output posedge_pulse,
        output negedge_pulse,
        output edge_count,
        output count_overflow
    );

endinterface

// File: rtl/cdc_input_channel.sv
// One conditioner channel: synchronizer chain, stability filter, edge pulses
// and a saturating edge counter with sticky overflow.
module cdc_input_channel
    import cdc_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_WIDTH     = 16,
    parameter int COUNT_MODE    = CNT_RISE,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 async_in,
    input  logic                 filter_bypass,
    input  logic                 count_clear,
    output logic                 level_out,
    output logic                 posedge_pulse,
    output logic                 negedge_pulse,
    output logic [CNT_WIDTH-1:0] edge_count,
    output logic                 count_overflow
);

    localparam int             FC_W    = filter_cnt_width(FILTER_CYCLES);
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FILTER_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;
    logic            sync_level;
    logic [FC_W-1:0] fc_q;
    logic            level_d;
    logic            count_event;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
        end
    end

    assign sync_level = sync_q[SYNC_STAGES-1];

    // The level only moves after FILTER_CYCLES consecutive samples disagree with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_out <= RESET_LEVEL;
            fc_q      <= '0;
        end else if (filter_bypass) begin
            level_out <= sync_level;
            fc_q      <= '0;
        end else if (sync_level == level_out) begin
            fc_q      <= '0;
        end else if (fc_q == FC_LAST) begin
            level_out <= sync_level;
            fc_q      <= '0;
        end else begin
            fc_q      <= fc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_d <= RESET_LEVEL;
        end else begin
            level_d <= level_out;
        end
    end

    assign posedge_pulse =  level_out & ~level_d;
    assign negedge_pulse = ~level_out &  level_d;

    // NOTE: combinational outputs get a default first so no path can infer a latch.
    always_comb begin
        count_event = 1'b0;
        case (COUNT_MODE)
            CNT_RISE: count_event = posedge_pulse;
            CNT_FALL: count_event = negedge_pulse;
            default:  count_event = posedge_pulse | negedge_pulse;
        endcase
    end

    // Clear wins over a coincident edge; an increment attempted at all-ones saturates.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            edge_count     <= '0;
            count_overflow <= 1'b0;
        end else if (count_clear) begin
            edge_count     <= '0;
            count_overflow <= 1'b0;
        end else if (count_event) begin
            if (&edge_count) begin
                count_overflow <= 1'b1;
            end else begin
                edge_count <= edge_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cdc_input_conditioner.sv
// Multi-channel conditioner for asynchronous level inputs entering the clk domain.
// Replicates one independent channel per input bit and packs the results.
module cdc_input_conditioner
    import cdc_pkg::*;
#(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_WIDTH     = 16,
    parameter int COUNT_MODE    = CNT_RISE,
    parameter bit RESET_LEVEL   = 1'b0
) (
    input logic                    clk,
    input logic                    reset,
    cdc_input_conditioner_if.slave io
);

    logic [CHANNELS-1:0]           level_vec;
    logic [CHANNELS-1:0]           pos_vec;
    logic [CHANNELS-1:0]           neg_vec;
    logic [CHANNELS-1:0]           ovf_vec;
    logic [CHANNELS*CNT_WIDTH-1:0] count_vec;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_channel
        cdc_input_channel #(
            .SYNC_STAGES  (SYNC_STAGES),
            .FILTER_CYCLES(FILTER_CYCLES),
            .CNT_WIDTH    (CNT_WIDTH),
            .COUNT_MODE   (COUNT_MODE),
            .RESET_LEVEL  (RESET_LEVEL)
        ) u_channel (
            .clk           (clk),
            .reset         (reset),
            .async_in      (io.async_in[ch]),
            .filter_bypass (io.filter_bypass[ch]),
            .count_clear   (io.count_clear),
            .level_out     (level_vec[ch]),
            .posedge_pulse (pos_vec[ch]),
            .negedge_pulse (neg_vec[ch]),
            .edge_count    (count_vec[ch*CNT_WIDTH +: CNT_WIDTH]),
            .count_overflow(ovf_vec[ch])
        );
    end

    assign io.level_out      = level_vec;
    assign io.posedge_pulse  = pos_vec;
    assign io.negedge_pulse  = neg_vec;
    assign io.edge_count     = count_vec;
    assign io.count_overflow = ovf_vec;

endmodule

// File: tb/tb_cdc_input_conditioner.sv
// Self-checking bench: two conditioner instances (rise-only/16-bit and both-edges/4-bit)
// share stimulus and are compared each cycle against a window-based reference model.
module tb_cdc_input_conditioner;
    import cdc_pkg::*;

    localparam int CH   = 4;
    localparam int SS   = 2;
    localparam int FC   = 4;
    localparam int WA   = 16;
    localparam int WB   = 4;
    localparam int MAXE = 16384;

    logic          clk = 1'b0;
    logic          reset;
    logic [CH-1:0] ain;
    logic [CH-1:0] byp;
    logic          clr;

    cdc_input_conditioner_if #(.CHANNELS(CH), .CNT_WIDTH(WA)) if_a ();
    cdc_input_conditioner_if #(.CHANNELS(CH), .CNT_WIDTH(WB)) if_b ();

    assign if_a.async_in      = ain;
    assign if_a.filter_bypass = byp;
    assign if_a.count_clear   = clr;
    assign if_b.async_in      = ain;
    assign if_b.filter_bypass = byp;
    assign if_b.count_clear   = clr;

    cdc_input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC),
        .CNT_WIDTH(WA), .COUNT_MODE(CNT_RISE), .RESET_LEVEL(1'b0)
    ) dut_a (.clk(clk), .reset(reset), .io(if_a));

    cdc_input_conditioner #(
        .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC),
        .CNT_WIDTH(WB), .COUNT_MODE(CNT_BOTH), .RESET_LEVEL(1'b0)
    ) dut_b (.clk(clk), .reset(reset), .io(if_b));

    always #5 clk = ~clk;

    int n_checks;
    int n_fail;

    task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    // Reference model: history of sampled inputs indexed by edge number since reset.
    int            edge_n;
    logic [CH-1:0] in_hist  [MAXE];
    logic [CH-1:0] byp_hist [MAXE];
    logic [CH-1:0] m_lvl;
    logic [CH-1:0] m_prev;
    int            m_cnt_a [CH];
    int            m_cnt_b [CH];
    logic [CH-1:0] m_ovf_a;
    logic [CH-1:0] m_ovf_b;

    // Value the synchronized input presents at edge k: the raw input SS edges earlier.
    function automatic logic s_at(input int k, input int c);
        if (k - SS < 1) return 1'b0;
        return in_hist[k-SS][c];
    endfunction

    task automatic model_reset();
        edge_n  = 0;
        m_lvl   = '0;
        m_prev  = '0;
        m_ovf_a = '0;
        m_ovf_b = '0;
        for (int c = 0; c < CH; c++) begin
            m_cnt_a[c] = 0;
            m_cnt_b[c] = 0;
        end
    endtask

    task automatic model_step();
        logic [CH-1:0] rise;
        logic [CH-1:0] fall;
        logic [CH-1:0] nxt;
        bit            stable;
        rise = m_lvl & ~m_prev;
        fall = ~m_lvl & m_prev;
        edge_n++;
        if (edge_n >= MAXE) begin
            $display("FAIL model_history: edge %0d, limit %0d", edge_n, MAXE);
            n_fail++;
            $fatal(1, "model history exhausted");
        end
        in_hist[edge_n]  = ain;
        byp_hist[edge_n] = byp;
        for (int c = 0; c < CH; c++) begin
            if (clr) begin
                m_cnt_a[c] = 0; m_ovf_a[c] = 1'b0;
                m_cnt_b[c] = 0; m_ovf_b[c] = 1'b0;
            end else begin
                if (rise[c]) begin
                    if (m_cnt_a[c] == (1 << WA) - 1) m_ovf_a[c] = 1'b1;
                    else m_cnt_a[c]++;
                end
                if (rise[c] || fall[c]) begin
                    if (m_cnt_b[c] == (1 << WB) - 1) m_ovf_b[c] = 1'b1;
                    else m_cnt_b[c]++;
                end
            end
            nxt[c] = m_lvl[c];
            if (byp[c]) begin
                nxt[c] = s_at(edge_n, c);
            end else begin
                // Level flips when the last FC filtered samples all disagree with it.
                stable = 1'b1;
                for (int j = edge_n - FC + 1; j <= edge_n; j++) begin
                    if (j < 1) stable = 1'b0;
                    else if (byp_hist[j][c] || s_at(j, c) == m_lvl[c]) stable = 1'b0;
                end
                if (stable) nxt[c] = ~m_lvl[c];
            end
        end
        m_prev = m_lvl;
        m_lvl  = nxt;
    endtask

    function automatic logic [CH*WA-1:0] exp_count_a();
        logic [CH*WA-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) v[c*WA +: WA] = WA'(m_cnt_a[c]);
        return v;
    endfunction

    function automatic logic [CH*WB-1:0] exp_count_b();
        logic [CH*WB-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) v[c*WB +: WB] = WB'(m_cnt_b[c]);
        return v;
    endfunction

    task automatic compare_all();
        check("level_a", if_a.level_out,      m_lvl);
        check("pos_a",   if_a.posedge_pulse,  m_lvl & ~m_prev);
        check("neg_a",   if_a.negedge_pulse,  ~m_lvl & m_prev);
        check("count_a", if_a.edge_count,     exp_count_a());
        check("ovf_a",   if_a.count_overflow, m_ovf_a);
        check("level_b", if_b.level_out,      m_lvl);
        check("pos_b",   if_b.posedge_pulse,  m_lvl & ~m_prev);
        check("neg_b",   if_b.negedge_pulse,  ~m_lvl & m_prev);
        check("count_b", if_b.edge_count,     exp_count_b());
        check("ovf_b",   if_b.count_overflow, m_ovf_b);
    endtask

    // One clock edge: advance the model with the inputs present at that edge, then compare.
    task automatic tick();
        @(posedge clk);
        if (!reset) model_step();
        #1;
        compare_all();
    endtask

    int rise_at [CH];
    int npos    [CH];
    int nneg    [CH];
    int nhigh   [CH];

    // Drive masked channels high for hi_len edges (forever if negative) and observe dut_a.
    task automatic watch(input logic [CH-1:0] mask, input int hi_len, input int cycles);
        for (int c = 0; c < CH; c++) begin
            rise_at[c] = -1; npos[c] = 0; nneg[c] = 0; nhigh[c] = 0;
        end
        for (int i = 1; i <= cycles; i++) begin
            for (int c = 0; c < CH; c++)
                if (mask[c]) ain[c] = (hi_len < 0) ? 1'b1 : (i <= hi_len);
            tick();
            for (int c = 0; c < CH; c++) begin
                if (if_a.level_out[c]) begin
                    nhigh[c]++;
                    if (rise_at[c] < 0) rise_at[c] = i;
                end
                if (if_a.posedge_pulse[c]) npos[c]++;
                if (if_a.negedge_pulse[c]) nneg[c]++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1; ain = '0; byp = '0; clr = 1'b0;
        model_reset();
        repeat (3) tick();
        check("reset_level", if_a.level_out, 0);
        check("reset_count", if_a.edge_count, 0);
        reset = 1'b0;
        repeat (3) tick();

        // Filtered latency on channel 0.
        watch(4'b0001, -1, 12);
        check("filt_rise_edge", rise_at[0], 6);
        check("filt_pos_width", npos[0], 1);
        check("filt_count",     if_a.edge_count[0 +: WA], 1);
        watch(4'b0001, 0, 12);
        check("filt_fall_neg", nneg[0], 1);

        // Glitch rejection on channel 1.
        watch(4'b0010, 3, 16);
        check("glitch3_high",  nhigh[1], 0);
        check("glitch3_pos",   npos[1], 0);
        check("glitch3_count", if_a.edge_count[WA +: WA], 0);
        watch(4'b0010, 4, 16);
        check("glitch4_pos",  npos[1], 1);
        check("glitch4_neg",  nneg[1], 1);
        check("glitch4_high", nhigh[1], 4);

        // Bypass on channel 2 with a single-cycle input pulse.
        byp = 4'b0100;
        repeat (2) tick();
        watch(4'b0100, 1, 8);
        check("byp_rise_edge", rise_at[2], 3);
        check("byp_high",      nhigh[2], 1);
        check("byp_pos",       npos[2], 1);
        check("byp_neg",       nneg[2], 1);
        byp = '0;
        repeat (4) tick();

        // Simultaneous rising edges with mixed bypass settings.
        byp = 4'b0101;
        repeat (2) tick();
        watch(4'b1111, -1, 10);
        for (int c = 0; c < CH; c++) begin
            check($sformatf("indep_rise_ch%0d", c), rise_at[c], byp[c] ? 3 : 6);
            check($sformatf("indep_pos_ch%0d", c),  npos[c], 1);
        end
        watch(4'b1111, 0, 10);
        byp = '0;
        repeat (3) tick();

        // Saturation of the 4-bit both-edge counter on channel 3.
        clr = 1'b1; tick(); clr = 1'b0;
        for (int p = 0; p < 10; p++) watch(4'b1000, 5, 10);
        repeat (4) tick();
        check("sat_count_b", if_b.edge_count[3*WB +: WB], 15);
        check("sat_ovf_b",   if_b.count_overflow[3], 1);
        check("sat_count_a", if_a.edge_count[3*WA +: WA], 10);

        // Clear coinciding with a counted edge.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            ain[3] = 1'b1;
            tick();
            if (if_b.posedge_pulse[3]) found = 1'b1;
        end
        check("clr_edge_seen", found, 1);
        clr = 1'b1; tick(); clr = 1'b0;
        check("clr_edge_count_b", if_b.edge_count[3*WB +: WB], 0);
        check("clr_edge_ovf_b",   if_b.count_overflow[3], 0);
        check("clr_edge_count_a", if_a.edge_count[3*WA +: WA], 0);
        tick();
        check("clr_hold_count_b", if_b.edge_count[3*WB +: WB], 0);
        watch(4'b1000, 0, 10);

        // Asynchronous reset mid-operation with level high and a count of 5.
        clr = 1'b1; tick(); clr = 1'b0;
        for (int p = 0; p < 4; p++) watch(4'b0001, 5, 10);
        watch(4'b0001, -1, 8);
        repeat (2) tick();
        check("pre_rst_level", if_a.level_out[0], 1);
        check("pre_rst_count", if_a.edge_count[0 +: WA], 5);
        tick();
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_level", if_a.level_out, 0);
        check("rst_async_count", if_a.edge_count, 0);
        check("rst_async_pulse", {if_a.posedge_pulse, if_a.negedge_pulse}, 0);
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        watch(4'b0001, -1, 12);
        check("post_rst_rise_edge", rise_at[0], 6);
        check("post_rst_pos",       npos[0], 1);

        // Randomized traffic with occasional bypass changes and clears.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 4) == 0) ain[c] = ~ain[c];
            if (cyc % 250 == 0) byp = CH'($urandom);
            clr = ($urandom_range(0, 31) == 0);
            tick();
        end
        clr = 1'b0;
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
